// File: rtl/geo_reg_ext.sv
// geoRAM-style Window/Block mapper with readback, control/status registers,
// block-count masking and auto-increment streaming through the $DExx window.
module geo_reg_ext #(
  parameter int         BLOCK_W  = 8,
  parameter int         WINDOW_W = 6,
  parameter logic [3:0] DEV_ID   = 4'hA
) (
  input  logic                PHI2,
  input  logic                RESET,
  input  logic                RegSEL,
  input  logic                WinSEL,
  input  logic                nWE,
  input  logic [7:0]          A,
  input  logic [7:0]          WRD,
  output logic [7:0]          RDD,
  output logic                RDOE,
  output logic [BLOCK_W-1:0]  Block,
  output logic [WINDOW_W-1:0] Window
);

  logic [WINDOW_W-1:0] win_q, win_d;
  logic [BLOCK_W-1:0]  blk_q, blk_d, blk_inc, mask;
  logic                ainc_q, ainc_d, wrap_q, wrap_d;
  logic [2:0]          size_q, size_d;
  logic                dec, wr, rd_stat, inc;
  logic [1:0]          idx;

  // Keep max(1, BLOCK_W - SIZE) low bits of the block number.
  function automatic logic [BLOCK_W-1:0] mk_mask(input logic [2:0] size);
    logic [BLOCK_W-1:0] m;
    int keep;
    keep = BLOCK_W - int'(size);
    if (keep < 1) keep = 1;
    for (int i = 0; i < BLOCK_W; i++) m[i] = (i < keep);
    return m;
  endfunction

  assign mask    = mk_mask(size_q);
  assign dec     = RegSEL & A[7] & A[6];
  assign idx     = A[1:0];
  assign wr      = dec & ~nWE;
  assign rd_stat = dec & nWE & (idx == 2'b11);
  assign inc     = ainc_q & WinSEL & ~RegSEL & (A == 8'hFF);
  assign blk_inc = (blk_q + BLOCK_W'(1)) & mask;

  always_comb begin
    win_d  = win_q;
    blk_d  = blk_q;
    ainc_d = ainc_q;
    size_d = size_q;
    wrap_d = wrap_q;
    if (rd_stat) wrap_d = 1'b0;
    if (wr) begin
      case (idx)
        2'b00: win_d = WINDOW_W'(WRD);
        2'b01: blk_d = BLOCK_W'(WRD) & mask;
        2'b10: begin
          ainc_d = WRD[0];
          size_d = WRD[3:1];
        end
        default: ;
      endcase
    end
    // Increment is only possible with RegSEL low, so it never collides with a write.
    if (inc) begin
      if (&win_q) begin
        win_d = '0;
        blk_d = blk_inc;
        if (blk_inc == '0) wrap_d = 1'b1;
      end else begin
        win_d = win_q + WINDOW_W'(1);
      end
    end
  end

  always_ff @(negedge PHI2) begin
    if (RESET) begin
      win_q  <= '0;
      blk_q  <= '0;
      ainc_q <= 1'b0;
      size_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      win_q  <= win_d;
      blk_q  <= blk_d;
      ainc_q <= ainc_d;
      size_q <= size_d;
      wrap_q <= wrap_d;
    end
  end

  assign RDOE = dec & nWE;

  always_comb begin
    RDD = 8'h00;
    if (RDOE) begin
      case (idx)
        2'b00:   RDD = 8'(win_q);
        2'b01:   RDD = 8'(blk_q);
        2'b10:   RDD = {4'b0000, size_q, ainc_q};
        default: RDD = {wrap_q, 3'b000, DEV_ID};
      endcase
    end
  end

  assign Block  = blk_q;
  assign Window = win_q;

endmodule

// File: tb/tb_geo_reg_ext.sv
// Directed bench for geo_reg_ext: registers at $DFFC..$DFFF, window at $DEFF.
module tb_geo_reg_ext;

  logic       PHI2 = 1'b1;
  logic       RESET, RegSEL, WinSEL, nWE;
  logic [7:0] A, WRD, RDD;
  logic       RDOE;
  logic [7:0] Block;
  logic [5:0] Window;

  int vectors = 0;
  int miscompares = 0;

  geo_reg_ext dut (
    .PHI2(PHI2), .RESET(RESET), .RegSEL(RegSEL), .WinSEL(WinSEL), .nWE(nWE),
    .A(A), .WRD(WRD), .RDD(RDD), .RDOE(RDOE), .Block(Block), .Window(Window)
  );

  always #5 PHI2 = ~PHI2;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive after the rising edge, state updates on the falling edge.
  task automatic bus(input logic rs, input logic ws, input logic nwe,
                     input logic [7:0] a, input logic [7:0] d);
    @(posedge PHI2);
    RegSEL = rs; WinSEL = ws; nWE = nwe; A = a; WRD = d;
    @(negedge PHI2);
    #1;
    RegSEL = 1'b0; WinSEL = 1'b0; nWE = 1'b1;
  endtask

  task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
    @(posedge PHI2);
    RegSEL = 1'b1; WinSEL = 1'b0; nWE = 1'b1; A = a; WRD = 8'h00;
    #1;
    chk({tag, "_oe"}, {7'b0, RDOE}, 8'h01);
    chk(tag, RDD, exp);
    @(negedge PHI2);
    #1;
    RegSEL = 1'b0;
  endtask

  task automatic wreg(input logic [7:0] a, input logic [7:0] d);
    bus(1'b1, 1'b0, 1'b0, a, d);
  endtask

  task automatic winff();
    bus(1'b0, 1'b1, 1'b1, 8'hFF, 8'h00);
  endtask

  initial begin
    RESET = 1'b1; RegSEL = 1'b0; WinSEL = 1'b0; nWE = 1'b1; A = 8'h00; WRD = 8'h00;
    @(negedge PHI2); #1;
    RESET = 1'b0;
    chk("rst_block", Block, 8'h00);
    chk("rst_window", {2'b0, Window}, 8'h00);
    chk("rst_rdoe", {7'b0, RDOE}, 8'h00);
    chk("rst_rdd", RDD, 8'h00);

    // Legacy pair
    wreg(8'hFD, 8'h5A);
    wreg(8'hFC, 8'h3F);
    chk("wr_block", Block, 8'h5A);
    chk("wr_window", {2'b0, Window}, 8'h3F);
    rd("rd_block", 8'hFD, 8'h5A);
    rd("rd_window", 8'hFC, 8'h3F);

    // Auto-increment across a page and a block boundary
    wreg(8'hFE, 8'h01);
    wreg(8'hFC, 8'h3E);
    wreg(8'hFD, 8'h10);
    winff();
    chk("inc1_window", {2'b0, Window}, 8'h3F);
    chk("inc1_block", Block, 8'h10);
    winff();
    chk("inc2_window", {2'b0, Window}, 8'h00);
    chk("inc2_block", Block, 8'h11);
    rd("inc2_status", 8'hFF, 8'h0A);
    bus(1'b0, 1'b1, 1'b1, 8'hFE, 8'h00);
    chk("win_notff", {2'b0, Window}, 8'h00);

    // SIZE=3 masking, wrap flag, clear-on-read
    wreg(8'hFE, 8'h07);
    rd("rd_ctrl", 8'hFE, 8'h07);
    wreg(8'hFD, 8'hFF);
    chk("mask_block", Block, 8'h1F);
    wreg(8'hFC, 8'h3F);
    bus(1'b0, 1'b1, 1'b0, 8'hFF, 8'h00);
    chk("wrap_block", Block, 8'h00);
    chk("wrap_window", {2'b0, Window}, 8'h00);
    rd("status_wrap", 8'hFF, 8'h8A);
    rd("status_clr", 8'hFF, 8'h0A);

    // SIZE=7 keeps a single block bit; upper CTRL bits read 0
    wreg(8'hFE, 8'hFF);
    rd("ctrl_upper0", 8'hFE, 8'h0F);
    wreg(8'hFD, 8'hFF);
    chk("mask_min", Block, 8'h01);

    // RegSEL and WinSEL together: register access only
    wreg(8'hFE, 8'h01);
    wreg(8'hFC, 8'h3F);
    bus(1'b1, 1'b1, 1'b0, 8'hFD, 8'h33);
    chk("both_block", Block, 8'h33);
    chk("both_window", {2'b0, Window}, 8'h3F);
    bus(1'b1, 1'b1, 1'b0, 8'hFF, 8'h77);
    chk("both_ff_block", Block, 8'h33);
    chk("both_ff_window", {2'b0, Window}, 8'h3F);

    // Reset wins over a write
    @(posedge PHI2);
    RESET = 1'b1; RegSEL = 1'b1; nWE = 1'b0; A = 8'hFD; WRD = 8'h44;
    @(negedge PHI2); #1;
    RESET = 1'b0; RegSEL = 1'b0; nWE = 1'b1;
    chk("rstwr_block", Block, 8'h00);
    chk("rstwr_window", {2'b0, Window}, 8'h00);

    // Reset wins over an increment
    wreg(8'hFE, 8'h01);
    wreg(8'hFC, 8'h3F);
    wreg(8'hFD, 8'h22);
    @(posedge PHI2);
    RESET = 1'b1; WinSEL = 1'b1; nWE = 1'b1; A = 8'hFF;
    @(negedge PHI2); #1;
    RESET = 1'b0; WinSEL = 1'b0;
    chk("rstinc_block", Block, 8'h00);
    chk("rstinc_window", {2'b0, Window}, 8'h00);
    rd("rst_ctrl", 8'hFE, 8'h00);
    rd("rst_status", 8'hFF, 8'h0A);

    // AUTOINC off: window accesses at FF are inert; STATUS is read-only
    wreg(8'hFD, 8'h5A);
    wreg(8'hFC, 8'h3F);
    for (int i = 0; i < 256; i++) winff();
    chk("noinc_block", Block, 8'h5A);
    chk("noinc_window", {2'b0, Window}, 8'h3F);
    wreg(8'hFF, 8'hFF);
    rd("status_ro", 8'hFF, 8'h0A);
    chk("status_ro_block", Block, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
